// File: rtl/clk_ctrl_pkg.sv
// clk_ctrl_pkg: shared types, defaults and divisor check for the core-clock divider
package clk_ctrl_pkg;
  localparam int DIV_W_D       = 4;
  localparam int DEFAULT_DIV_D = 4;
  localparam int SETTLE_CYC_D  = 8;
  localparam int SCNT_W_D      = $clog2(SETTLE_CYC_D + 1);
  typedef enum logic [1:0] {RUN, DRAIN, SETTLE, LOAD} state_t;
  function automatic logic div_valid(input int n, input int w);
    return !n[0] && n >= 2 && n <= (1 << w) - 2;
  endfunction
endpackage

// File: rtl/clk_div_core.sv
// clk_div_core: half-period phase counter and toggle flop producing a 50% duty clock
//   osc_clk/reset : source clock, async active-high reset
//   run           : advance the counter; when low the counter and core_clk hold
//   clear         : zero the counter and force core_clk low (has priority over run)
//   div           : even divide ratio N, the counter wraps at N/2-1
//   core_clk      : registered divided clock
//   count         : current phase count
module clk_div_core #(
  parameter int DIV_W = 4
) (
  input  logic             osc_clk,
  input  logic             reset,
  input  logic             run,
  input  logic             clear,
  input  logic [DIV_W-1:0] div,
  output logic             core_clk,
  output logic [DIV_W-1:0] count
);
  logic [DIV_W-1:0] last;
  logic             wrap;
  assign last = (div >> 1) - DIV_W'(1);
  assign wrap = count == last;
  always_ff @(posedge osc_clk or posedge reset)
    if (reset) begin
      count    <= '0;
      core_clk <= 1'b0;
    end else if (clear) begin
      count    <= '0;
      core_clk <= 1'b0;
    end else if (run) begin
      count    <= wrap ? '0 : count + DIV_W'(1);
      core_clk <= core_clk ^ wrap;
    end
endmodule

// File: rtl/clk_div_ctrl.sv
// clk_div_ctrl: programmable core-clock divider with glitch-free divisor reconfiguration
//   osc_clk/reset     : oscillator clock, async active-high reset
//   cfg_req/cfg_div   : request pulse and requested divisor
//   cfg_ack/cfg_err   : one-cycle pulses, new divisor applied / request rejected
//   busy              : reconfiguration in progress, requests ignored
//   core_clk          : divided clock; core_clk_en high while it is toggling
//   cur_div           : divisor currently applied
module clk_div_ctrl
  import clk_ctrl_pkg::*;
#(
  parameter int DIV_W       = DIV_W_D,
  parameter int DEFAULT_DIV = DEFAULT_DIV_D,
  parameter int SETTLE_CYC  = SETTLE_CYC_D
) (
  input  logic             osc_clk,
  input  logic             reset,
  input  logic             cfg_req,
  input  logic [DIV_W-1:0] cfg_div,
  output logic             cfg_ack,
  output logic             cfg_err,
  output logic             busy,
  output logic             core_clk,
  output logic             core_clk_en,
  output logic [DIV_W-1:0] cur_div
);
  localparam int SW = $clog2(SETTLE_CYC + 1);
  state_t           state, state_n;
  logic [DIV_W-1:0] pend_div, count;
  logic [SW-1:0]    scnt;
  logic             req_ok, run, clear;
  assign req_ok = cfg_req && div_valid(int'(cfg_div), DIV_W);
  // While draining, the divider stops the moment core_clk is low so the low phase stretches into the settle window
  assign run    = state == RUN || (state == DRAIN && core_clk);
  assign clear  = state == LOAD;
  clk_div_core #(.DIV_W(DIV_W)) u_core (
    .osc_clk  (osc_clk),
    .reset    (reset),
    .run      (run),
    .clear    (clear),
    .div      (cur_div),
    .core_clk (core_clk),
    .count    (count)
  );
  always_comb begin
    state_n = state;
    case (state)
      RUN:     state_n = req_ok ? DRAIN : RUN;
      DRAIN:   state_n = core_clk ? DRAIN : SETTLE;
      SETTLE:  state_n = scnt == SW'(SETTLE_CYC - 1) ? LOAD : SETTLE;
      LOAD:    state_n = RUN;
      default: state_n = RUN;
    endcase
  end
  always_ff @(posedge osc_clk or posedge reset)
    if (reset) begin
      state       <= RUN;
      pend_div    <= DIV_W'(DEFAULT_DIV);
      cur_div     <= DIV_W'(DEFAULT_DIV);
      scnt        <= '0;
      busy        <= 1'b0;
      cfg_ack     <= 1'b0;
      cfg_err     <= 1'b0;
      core_clk_en <= 1'b1;
    end else begin
      state       <= state_n;
      if (state == RUN && req_ok) pend_div <= cfg_div;
      if (clear) cur_div <= pend_div;
      scnt        <= state == SETTLE ? scnt + SW'(1) : '0;
      busy        <= state_n != RUN;
      cfg_ack     <= clear;
      cfg_err     <= state == RUN && cfg_req && !req_ok;
      core_clk_en <= state_n == RUN || state_n == DRAIN;
    end
  // The phase count must always sit inside the half-period of the divisor in effect
  assert property (@(posedge osc_clk) disable iff (reset) count < (cur_div >> 1));
endmodule

// File: tb/tb_clk_div_ctrl.sv
// tb_clk_div_ctrl: self-checking bench for clk_div_ctrl with event scoreboard and pulse-width checker
module tb_clk_div_ctrl;
  logic       osc_clk = 0, reset = 0, cfg_req = 0;
  logic [3:0] cfg_div = 0;
  logic       cfg_ack, cfg_err, busy, core_clk, core_clk_en;
  logic [3:0] cur_div;
  typedef struct {logic err; logic [3:0] div;} ev_t;
  typedef struct {logic [3:0] div; logic err; int per;} vec_t;
  ev_t        sb[$];
  ev_t        mon_e;
  vec_t       vt[9];
  int         ncmp = 0, nerr = 0;
  int         cyc = 0, nr = 0, hl = 0, ll = 0, hi_last = 0, lo_last = 0, per = 0, lrise = 0, ack_cyc = 0;
  int         model_n = 4, prev_n = 4;
  logic       lastc = 0, en0_seen = 0;
  logic [3:0] tcur = 4;

  clk_div_ctrl dut (
    .osc_clk(osc_clk), .reset(reset), .cfg_req(cfg_req), .cfg_div(cfg_div),
    .cfg_ack(cfg_ack), .cfg_err(cfg_err), .busy(busy), .core_clk(core_clk),
    .core_clk_en(core_clk_en), .cur_div(cur_div)
  );

  always #5 osc_clk = ~osc_clk;

  task automatic chk(input string nm, input int act, input int exp);
    ncmp++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk_ge(input string nm, input int act, input int lo);
    ncmp++;
    if (act < lo) begin
      nerr++;
      $display("FAIL %s: got %0d, expected at least %0d (t=%0t)", nm, act, lo, $time);
    end
  endtask

  always @(negedge osc_clk) begin
    cyc++;
    if (reset) begin
      lastc   = 0;
      hl      = 0;
      ll      = 0;
      model_n = 4;
      prev_n  = 4;
    end else begin
      if (cfg_ack || cfg_err) begin
        if (sb.size() == 0) chk("sb_unexpected", int'(cfg_ack) + int'(cfg_err), 0);
        else begin
          mon_e = sb.pop_front();
          chk("sb_err", int'(cfg_err), int'(mon_e.err));
          chk("sb_ack", int'(cfg_ack), int'(!mon_e.err));
          chk("sb_div", int'(cur_div), int'(mon_e.div));
          if (cfg_ack) begin
            prev_n  = model_n;
            model_n = int'(mon_e.div);
            ack_cyc = cyc;
          end
        end
      end
      if (!core_clk_en) begin
        en0_seen = 1;
        chk("gated_low", int'(core_clk), 0);
      end
      if (core_clk && !lastc) begin
        nr++;
        per     = cyc - lrise;
        lrise   = cyc;
        lo_last = ll;
        chk_ge("low_pulse", ll, (prev_n < model_n ? prev_n : model_n) / 2);
        hl = 1;
      end else if (!core_clk && lastc) begin
        hi_last = hl;
        chk_ge("high_pulse", hl, model_n / 2);
        ll = 1;
      end else if (core_clk) hl++;
      else ll++;
      lastc = core_clk;
    end
  end

  task automatic drive(input logic [3:0] d, input logic push, input logic err, input logic [3:0] exp);
    ev_t e;
    @(negedge osc_clk);
    cfg_req = 1;
    cfg_div = d;
    if (push) begin
      e.err = err;
      e.div = exp;
      sb.push_back(e);
    end
    @(negedge osc_clk);
    cfg_req = 0;
  endtask

  task automatic wait_empty(input string nm);
    int t = 0;
    while (sb.size() != 0 && t < 400) begin
      @(negedge osc_clk);
      t++;
    end
    chk(nm, sb.size(), 0);
  endtask

  task automatic wait_rises(input int n, input string nm);
    int s = nr;
    int t = 0;
    while (nr < s + n && t < 200) begin
      @(negedge osc_clk);
      t++;
    end
    chk(nm, nr - s, n);
  endtask

  task automatic chk_period(input string nm, input int n);
    wait_rises(2, {nm, "_rises"});
    chk({nm, "_per"}, per, n);
    chk({nm, "_hi"}, hi_last, n / 2);
    chk({nm, "_lo"}, lo_last, n / 2);
  endtask

  initial begin
    int t;
    vt[0] = '{4'd5, 1'b1, 4};
    vt[1] = '{4'd0, 1'b1, 4};
    vt[2] = '{4'd15, 1'b1, 4};
    vt[3] = '{4'd4, 1'b0, 4};
    vt[4] = '{4'd6, 1'b0, 6};
    vt[5] = '{4'd9, 1'b1, 6};
    vt[6] = '{4'd14, 1'b0, 14};
    vt[7] = '{4'd2, 1'b0, 2};
    vt[8] = '{4'd4, 1'b0, 4};
    #1 reset = 1;
    repeat (3) @(negedge osc_clk);
    chk("rst_core_clk", int'(core_clk), 0);
    chk("rst_en", int'(core_clk_en), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_ack", int'(cfg_ack), 0);
    chk("rst_err", int'(cfg_err), 0);
    chk("rst_cur_div", int'(cur_div), 4);
    reset = 0;
    chk_period("idle", 4);

    foreach (vt[i]) begin
      drive(vt[i].div, 1, vt[i].err, vt[i].err ? tcur : vt[i].div);
      chk($sformatf("v%0d_err_next", i), int'(cfg_err), int'(vt[i].err));
      chk($sformatf("v%0d_busy_next", i), int'(busy), int'(!vt[i].err));
      wait_empty($sformatf("v%0d_event", i));
      if (!vt[i].err) tcur = vt[i].div;
      chk_period($sformatf("v%0d", i), vt[i].per);
      chk($sformatf("v%0d_cur_div", i), int'(cur_div), int'(tcur));
      chk($sformatf("v%0d_busy", i), int'(busy), 0);
    end

    t = 0;
    while (!core_clk && t < 20) begin
      @(negedge osc_clk);
      t++;
    end
    chk("see_high", int'(core_clk), 1);
    en0_seen = 0;
    t = nr;
    drive(4'd6, 1, 1'b0, 4'd6);
    wait_rises(1, "chg6_rise");
    chk("chg6_rise_count", nr - t, 1);
    chk_ge("chg6_drain_low", lo_last, 10);
    chk("chg6_ack_to_rise", lrise - ack_cyc, 3);
    chk("chg6_gated", int'(en0_seen), 1);
    chk("chg6_sb", sb.size(), 0);
    chk_period("chg6", 6);
    tcur = 6;

    drive(4'd8, 1, 1'b0, 4'd8);
    repeat (2) @(negedge osc_clk);
    drive(4'd2, 0, 1'b0, 4'd0);
    chk("ign_busy", int'(busy), 1);
    wait_empty("ign_event");
    repeat (30) @(negedge osc_clk);
    chk("ign_cur_div", int'(cur_div), 8);
    chk_period("ign", 8);

    drive(4'd10, 0, 1'b0, 4'd0);
    t = 0;
    while (core_clk_en && t < 40) begin
      @(negedge osc_clk);
      t++;
    end
    chk("reach_settle", int'(core_clk_en), 0);
    #3 reset = 1;
    #1;
    chk("mid_rst_core_clk", int'(core_clk), 0);
    chk("mid_rst_en", int'(core_clk_en), 1);
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_ack", int'(cfg_ack), 0);
    chk("mid_rst_cur_div", int'(cur_div), 4);
    repeat (2) @(negedge osc_clk);
    reset = 0;
    tcur = 4;
    repeat (30) @(negedge osc_clk);
    chk("post_rst_cur_div", int'(cur_div), 4);
    chk_period("post_rst", 4);

    drive(4'd2, 1, 1'b0, 4'd2);
    wait_empty("b2b_ack2");
    drive(4'd14, 1, 1'b0, 4'd14);
    wait_empty("b2b_ack14");
    chk_period("b2b", 14);
    chk("b2b_cur_div", int'(cur_div), 14);

    repeat (20) @(negedge osc_clk);
    chk("sb_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", ncmp);
    $fatal(1, "watchdog");
  end
endmodule
